spi_master_multi: RTL and testbench

Parametrised SPI master, the successor to the fixed-format spi_master. It has configurable word width, SCLK divider and chip-select count, plus runtime-selectable SPI mode (CPOL/CPHA) and bit order. User logic drives it through a start/busy/done handshake, and it connects directly to spi_slave-style peripherals on SCLK/SS_N/MOSI/MISO.

---
 rtl/spi_master_multi.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master with runtime-selectable mode and bit order.
//
// A transfer is requested with start while idle. The word, slave index, CPOL, CPHA and
// bit order are captured at that moment, so later changes on those inputs do not affect
// the transfer in flight. Phase sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE,
// where every phase (and every SCLK half-period inside SHIFT) lasts CLK_DIV clk cycles.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               transfer request, only looked at in IDLE
//   tx_data, ss_sel     word to send and target slave index, captured on accept
//   cpol, cpha          SPI mode; cpol also sets the SCLK idle level while in IDLE
//   lsb_first           bit order, captured on accept
//   busy                high from the cycle after accept until back in IDLE
//   done                one-cycle pulse when rx_data is updated
//   rx_data             last received word, held until the next done
//   err                 one-cycle pulse when start names a slave that does not exist
//   SCLK, SS_N, MOSI    serial clock, active-low selects (at most one low), serial out
//   MISO                serial in
module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 4,
    parameter int SEL_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              err,
    output logic              SCLK,
    output logic [NUM_SS-1:0] SS_N,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = (DATA_W > 1) ? $clog2(2 * DATA_W) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_W - 1);
    // Entering the final half-period is the last trailing edge; no new bit follows it.
    localparam logic [HALF_W-1:0] HALF_LAST2 = HALF_W'(2 * DATA_W - 2);
    localparam logic [SEL_W:0]    SS_COUNT   = (SEL_W + 1)'(NUM_SS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                phase_end;
    logic                lead_edge, trail_edge, sample, present;
    logic                tx_bit;
    logic [DATA_W-1:0]   tx_shifted, rx_shifted;

    assign phase_end  = (cnt_q == CNT_LAST);
    assign tx_bit     = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    assign tx_shifted = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    assign rx_shifted = lsb_q ? ((rx_sh_q >> 1) | (DATA_W'(MISO) << (DATA_W - 1)))
                              : ((rx_sh_q << 1) | DATA_W'(MISO));

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        half_d     = half_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        ss_n_d     = ss_n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (start) begin
                    if ({1'b0, ss_sel} < SS_COUNT) begin
                        state_d = ST_SETUP;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        lsb_d   = lsb_first;
                        ss_n_d  = ~(NUM_SS'(1) << ss_sel);
                        rx_sh_d = '0;
                        if (!cpha) begin
                            // CPHA=0: the first bit must already be on MOSI before the
                            // first (sampling) edge, so it goes out on entry to SETUP.
                            mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                            tx_sh_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
                        end else begin
                            tx_sh_d = tx_data;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    half_d    = '0;
                    sclk_d    = ~cpol_q;
                    lead_edge = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                        // Even half-periods are entered by leading edges, odd by trailing.
                        if (half_q[0]) lead_edge = 1'b1;
                        else           trail_edge = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                    ss_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        sample  = (lead_edge & ~cpha_q) | (trail_edge & cpha_q);
        present = (lead_edge & cpha_q) | (trail_edge & ~cpha_q & (half_q != HALF_LAST2));
        if (sample) begin
            rx_sh_d = rx_shifted;
        end
        if (present) begin
            mosi_d  = tx_bit;
            tx_sh_d = tx_shifted;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ss_n_q    <= '1;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            ss_n_q    <= ss_n_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign err     = err_q;
    assign SCLK    = sclk_q;
    assign SS_N    = ss_n_q;
    assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed testbench for spi_master_multi. Three instances cover the default
// configuration (8-bit, CLK_DIV=4, 4 selects), a 3-select variant for the
// invalid-select path, and a 16-bit CLK_DIV=1 variant for back-to-back transfers.
module tb_spi_master_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic       start_a = 0, cpol_a = 0, cpha_a = 0, lsb_a = 0, loop_a = 1;
    logic [7:0] tx_a = 0;
    logic [1:0] sel_a = 0;
    logic       busy_a, done_a, err_a, sclk_a, mosi_a, miso_a;
    logic [7:0] rx_a;
    logic [3:0] ss_n_a;
    logic       slv_miso = 1'b0;

    assign miso_a = loop_a ? mosi_a : slv_miso;

    spi_master_multi #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .ss_sel(sel_a),
        .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .busy(busy_a), .done(done_a),
        .rx_data(rx_a), .err(err_a), .SCLK(sclk_a), .SS_N(ss_n_a), .MOSI(mosi_a),
        .MISO(miso_a)
    );

    // Slave model on instance A: counts SCLK edges while selected, samples MOSI on its
    // sampling edge (MSB-first shift-in) and, for CPHA=1, drives slv_word MSB-first.
    int         rise_cnt = 0, fall_cnt = 0, samp_cnt = 0, slv_idx = 0;
    logic [7:0] slv_rx = 8'h00;
    logic [7:0] slv_word = 8'h3C;
    logic       slv_sclk_prev = 1'b0;
    logic       slv_lead;

    always @(sclk_a or ss_n_a) begin
        if (ss_n_a == 4'hF) begin
            slv_idx = 0;
        end else if (sclk_a !== slv_sclk_prev) begin
            slv_lead = (sclk_a != cpol_a);
            if (sclk_a) rise_cnt++;
            else        fall_cnt++;
            if (slv_lead ^ cpha_a) begin
                samp_cnt++;
                slv_rx = {slv_rx[6:0], mosi_a};
            end else if (cpha_a) begin
                slv_miso = slv_word[7 - (slv_idx % 8)];
                slv_idx++;
            end
        end
        slv_sclk_prev = sclk_a;
    end

    // ---------------- instance B: 3 selects ----------------
    logic       start_b = 0;
    logic [3:0] tx_b = 0;
    logic [1:0] sel_b = 0;
    logic       busy_b, done_b, err_b, sclk_b, mosi_b;
    logic [3:0] rx_b;
    logic [2:0] ss_n_b;

    spi_master_multi #(.DATA_W(4), .CLK_DIV(2), .NUM_SS(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .ss_sel(sel_b),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .busy(busy_b), .done(done_b),
        .rx_data(rx_b), .err(err_b), .SCLK(sclk_b), .SS_N(ss_n_b), .MOSI(mosi_b),
        .MISO(mosi_b)
    );

    // ---------------- instance C: 16-bit, CLK_DIV=1 ----------------
    logic        start_c = 0;
    logic [15:0] tx_c = 0;
    logic        busy_c, done_c, err_c, sclk_c, mosi_c;
    logic [15:0] rx_c;
    logic [3:0]  ss_n_c;

    spi_master_multi #(.DATA_W(16), .CLK_DIV(1), .NUM_SS(4), .SEL_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .tx_data(tx_c), .ss_sel(2'd1),
        .cpol(1'b0), .cpha(1'b1), .lsb_first(1'b0), .busy(busy_c), .done(done_c),
        .rx_data(rx_c), .err(err_c), .SCLK(sclk_c), .SS_N(ss_n_c), .MOSI(mosi_c),
        .MISO(mosi_c)
    );

    // One transfer on instance A. Latencies are counted in clk edges after the accept edge.
    task automatic xfer_a(input string tag, input logic [7:0] tx, input logic [1:0] sel,
                          input logic cp, input logic ph, input logic lsb,
                          input logic [3:0] exp_ss);
        int r0, f0, s0, lat_done, lat_idle;
        lat_done = -1;
        lat_idle = -1;
        @(negedge clk);
        tx_a = tx; sel_a = sel; cpol_a = cp; cpha_a = ph; lsb_a = lsb;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_idle_sclk"}, sclk_a, cp);
        r0 = rise_cnt; f0 = fall_cnt; s0 = samp_cnt;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ss_n"}, ss_n_a, exp_ss);
        check({tag, "_busy"}, busy_a, 1'b1);
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done_a && lat_done < 0) lat_done = n;
            if (!busy_a) begin
                lat_idle = n;
                break;
            end
        end
        check({tag, "_done_lat"}, lat_done, 72);
        check({tag, "_busy_lat"}, lat_idle, 76);
        check({tag, "_rise"}, rise_cnt - r0, 8);
        check({tag, "_fall"}, fall_cnt - f0, 8);
        check({tag, "_samples"}, samp_cnt - s0, 8);
        check({tag, "_ss_after"}, ss_n_a, 4'hF);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vec_c [3];
        int dcnt, ecnt, k, hi_run;
        logic seen_low;
        vec_c[0] = 16'hBEEF;
        vec_c[1] = 16'h1234;
        vec_c[2] = 16'h8001;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a", {ss_n_a, sclk_a, mosi_a, busy_a, done_a, err_a, rx_a},
              {4'hF, 5'b0, 8'h00});
        check("reset_c", {ss_n_c, sclk_c, busy_c, rx_c}, {4'hF, 2'b0, 16'h0000});
        rst_n = 1'b1;

        // Mode 0, loopback
        loop_a = 1'b1;
        xfer_a("m0", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1110);
        check("m0_rx", rx_a, 8'hA5);
        check("m0_slv_rx", slv_rx, 8'hA5);

        // Mode 3 against slave model returning 0x3C
        loop_a = 1'b0;
        xfer_a("m3", 8'hC3, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1101);
        check("m3_rx", rx_a, 8'h3C);
        check("m3_slv_rx", slv_rx, 8'hC3);
        check("m3_sclk_idle", sclk_a, 1'b1);

        // Modes 1 and 2, LSB first, loopback; first bit out is 1 so slave MSB-first sees 0x80
        loop_a = 1'b1;
        xfer_a("m1", 8'h01, 2'd2, 1'b0, 1'b1, 1'b1, 4'b1011);
        check("m1_rx", rx_a, 8'h01);
        check("m1_slv_rx", slv_rx, 8'h80);
        xfer_a("m2", 8'h01, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0111);
        check("m2_rx", rx_a, 8'h01);
        check("m2_slv_rx", slv_rx, 8'h80);

        // Reset in the middle of SHIFT (mode 2, SCLK high at that point)
        @(negedge clk);
        tx_a = 8'hFF; sel_a = 2'd0; cpol_a = 1'b1; cpha_a = 1'b0; lsb_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("rst_pre_state", {busy_a, sclk_a, mosi_a, ss_n_a}, {3'b111, 4'b1110});
        rst_n = 1'b0;
        #1;
        check("rst_same_cycle", {ss_n_a, sclk_a, busy_a, done_a, mosi_a}, {4'hF, 4'b0000});
        repeat (3) @(negedge clk);
        check("rst_held", {ss_n_a, sclk_a, busy_a, done_a, rx_a}, {4'hF, 3'b000, 8'h00});
        rst_n = 1'b1;
        xfer_a("post_rst", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1110);
        check("post_rst_rx", rx_a, 8'h5A);

        // Invalid select on the 3-select instance
        @(negedge clk);
        sel_b = 2'd3; tx_b = 4'h6; start_b = 1'b1;
        @(posedge clk);
        #1;
        check("err_pulse", err_b, 1'b1);
        check("err_no_pins", {busy_b, ss_n_b, sclk_b, mosi_b}, {1'b0, 3'b111, 2'b00});
        @(negedge clk);
        start_b = 1'b0;
        @(posedge clk);
        #1;
        check("err_one_cycle", {err_b, busy_b, ss_n_b}, {2'b00, 3'b111});

        // Valid transfer on B with a start pulse while busy
        @(negedge clk);
        sel_b = 2'd2; tx_b = 4'h9; start_b = 1'b1;
        @(posedge clk);
        #1;
        check("b_ss_n", ss_n_b, 3'b011);
        start_b = 1'b0;
        dcnt = 0;
        ecnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_b) dcnt++;
            if (err_b) ecnt++;
            start_b = (n == 5);
            if (n == 5) sel_b = 2'd0;
        end
        start_b = 1'b0;
        check("b_single_done", dcnt, 1);
        check("b_no_err", ecnt, 0);
        check("b_rx", rx_b, 4'h9);
        check("b_idle", {busy_b, ss_n_b}, {1'b0, 3'b111});

        // Back-to-back on C with start held high
        k = 0;
        hi_run = 0;
        seen_low = 1'b0;
        @(negedge clk);
        tx_c = vec_c[0];
        start_c = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (ss_n_c == 4'hF) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) check("b2b_gap", hi_run, 2);
                seen_low = 1'b1;
                hi_run = 0;
            end
            if (done_c && k < 3) begin
                check("b2b_rx", rx_c, vec_c[k]);
                k++;
                if (k < 3) tx_c = vec_c[k];
                else       start_c = 1'b0;
            end
            if (k == 3 && !busy_c) break;
        end
        start_c = 1'b0;
        check("b2b_dones", k, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
